// File: rtl/spi_adc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_arbiter_if
// Purpose  : Requester and spi_master signal bundle for spi_adc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_adc_arbiter_if;
    logic        req0;
    logic [2:0]  chnl0;
    logic        req1;
    logic [2:0]  chnl1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [11:0] result;
    logic        timeout;
    logic        tmo_flag;
    logic        clr_tmo;
    logic [2:0]  chnl;
    logic        strt_cnv;
    logic [11:0] rslt;
    logic        cnv_cmplt;

    // Arbiter side.
    modport slave (
        input  req0, chnl0, req1, chnl1, clr_tmo, rslt, cnv_cmplt,
        output gnt0, gnt1, done0, done1, result, timeout, tmo_flag, chnl, strt_cnv
    );

    // Requesters plus spi_master side.
    modport master (
        output req0, chnl0, req1, chnl1, clr_tmo, rslt, cnv_cmplt,
        input  gnt0, gnt1, done0, done1, result, timeout, tmo_flag, chnl, strt_cnv
    );
endinterface
`default_nettype wire

// File: rtl/spi_adc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_arbiter
// Purpose  : Round-robin sharing of one SPI ADC master between two requesters,
//            with startup hold-off and hung-conversion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_adc_arbiter #(
    parameter int STARTUP_DLY    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    spi_adc_arbiter_if.slave bus
);

    localparam int STUP_W = (STARTUP_DLY > 1) ? $clog2(STARTUP_DLY) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [STUP_W-1:0] c_STUP_LAST = STUP_W'(STARTUP_DLY - 1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_BUSY    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_q;
    logic [STUP_W-1:0]  stup_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               cmplt_q;
    logic               rr_ptr_q;
    logic               owner_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic               done0_q;
    logic               done1_q;
    logic               timeout_q;
    logic               tmo_flag_q;
    logic               strt_cnv_q;
    logic [2:0]         chnl_q;
    logic [11:0]        result_q;

    logic               w_cmp_rise;
    logic               w_any_req;
    logic               w_pick1;
    logic               w_tmo_hit;

    assign w_cmp_rise = bus.cnv_cmplt & ~cmplt_q;
    assign w_any_req  = bus.req0 | bus.req1;
    // rr_ptr_q names the favoured requester when both are pending.
    assign w_pick1    = bus.req1 & (~bus.req0 | rr_ptr_q);
    assign w_tmo_hit  = (tmo_cnt_q == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STARTUP;
            stup_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            cmplt_q    <= 1'b1;
            rr_ptr_q   <= 1'b0;
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            timeout_q  <= 1'b0;
            tmo_flag_q <= 1'b0;
            strt_cnv_q <= 1'b0;
            chnl_q     <= 3'd0;
            result_q   <= 12'd0;
        end else begin
            cmplt_q    <= bus.cnv_cmplt;
            strt_cnv_q <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            timeout_q  <= 1'b0;
            if (bus.clr_tmo) begin
                tmo_flag_q <= 1'b0;
            end

            case (state_q)
                ST_STARTUP: begin
                    if (stup_cnt_q == c_STUP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        stup_cnt_q <= stup_cnt_q + STUP_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (w_any_req) begin
                        owner_q    <= w_pick1;
                        gnt0_q     <= ~w_pick1;
                        gnt1_q     <= w_pick1;
                        chnl_q     <= w_pick1 ? bus.chnl1 : bus.chnl0;
                        strt_cnv_q <= 1'b1;
                        // Counter restarts with the start pulse so it counts
                        // cycles elapsed since strt_cnv.
                        tmo_cnt_q  <= '0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    // Any completion edge seen here belongs to an older
                    // conversion and is deliberately not acted on.
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    state_q   <= ST_BUSY;
                end

                ST_BUSY: begin
                    if (w_cmp_rise) begin
                        result_q <= bus.rslt;
                        done0_q  <= ~owner_q;
                        done1_q  <= owner_q;
                        state_q  <= ST_DONE;
                    end else if (w_tmo_hit) begin
                        timeout_q  <= 1'b1;
                        tmo_flag_q <= 1'b1;
                        done0_q    <= ~owner_q;
                        done1_q    <= owner_q;
                        state_q    <= ST_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end

                ST_DONE: begin
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    rr_ptr_q <= ~owner_q;
                    state_q  <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_STARTUP;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.result   = result_q;
    assign bus.timeout  = timeout_q;
    assign bus.tmo_flag = tmo_flag_q;
    assign bus.chnl     = chnl_q;
    assign bus.strt_cnv = strt_cnv_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_adc_arbiter
// Purpose  : Self-checking bench: timestamp-level reference model, directed
//            scenarios and randomized traffic for spi_adc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_adc_arbiter;

    localparam int SDLY = 8;
    localparam int TMO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_adc_arbiter_if bus ();

    spi_adc_arbiter #(
        .STARTUP_DLY    (SDLY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one transaction described by its start and done times.
    int          cyc;
    bit          m_active;
    int          m_owner, m_tstrt, m_tdone, m_fav;
    bit          m_abort;
    logic [11:0] e_result;
    logic        e_flag;
    logic [2:0]  e_chnl;
    bit          prev_cm;

    // Stimulus controls.
    bit          p0, p1;
    int          req_mode;
    int          raise_pct, drop_pct, hang_pct, clr_pct;
    int          fix_len;
    bit          fix_hang, stale, clr_at_abort, clr_once;
    bit          fix_rslt_en, fix_ch_en;
    logic [11:0] fix_rslt;
    logic [2:0]  fix_ch0, fix_ch1;
    int          conv_len;
    bit          conv_hang;

    logic        r0, r1, cm, clr;
    logic [2:0]  ch0, ch1;
    logic [11:0] rs;

    int s_cyc[$], s_own[$], s_chn[$], d_cyc[$], d_tmo[$], d_res[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        s_cyc.delete(); s_own.delete(); s_chn.delete();
        d_cyc.delete(); d_tmo.delete(); d_res.delete();
    endtask

    task automatic model_reset();
        cyc = 0; m_active = 0; m_owner = 0; m_tstrt = -100; m_tdone = -1;
        m_fav = 0; m_abort = 0; e_result = '0; e_flag = 0; e_chnl = '0;
        prev_cm = 1; conv_len = 2; conv_hang = 0;
    endtask

    task automatic drive();
        if (req_mode == 1) begin
            r0 = 1; r1 = 1;
        end else if (req_mode == 2) begin
            r0 = 0; r1 = 1;
        end else begin
            if (!p0 && $urandom_range(0, 99) < raise_pct) p0 = 1;
            if (!p1 && $urandom_range(0, 99) < raise_pct) p1 = 1;
            if (p0 && m_active && m_owner == 0 && $urandom_range(0, 99) < drop_pct) p0 = 0;
            if (p1 && m_active && m_owner == 1 && $urandom_range(0, 99) < drop_pct) p1 = 0;
            r0 = p0; r1 = p1;
        end
        ch0 = fix_ch_en ? fix_ch0 : 3'($urandom);
        ch1 = fix_ch_en ? fix_ch1 : 3'($urandom);
        clr = clr_once || (clr_at_abort && m_active && cyc == m_tstrt + TMO - 1)
              || ($urandom_range(0, 99) < clr_pct);
        clr_once = 0;
        // spi_master behaviour: complete level low while converting.
        if (stale)
            cm = m_active && (cyc == m_tstrt || (!conv_hang && cyc >= m_tstrt + conv_len));
        else if (conv_hang)
            cm = !(m_active && cyc > m_tstrt);
        else
            cm = !(m_active && cyc > m_tstrt && cyc < m_tstrt + conv_len);
        rs = (fix_rslt_en && m_active && cyc >= m_tstrt + conv_len) ? fix_rslt : 12'($urandom);
        bus.req0 = r0; bus.req1 = r1; bus.chnl0 = ch0; bus.chnl1 = ch1;
        bus.clr_tmo = clr; bus.cnv_cmplt = cm; bus.rslt = rs;
    endtask

    task automatic cmp_upd();
        logic [31:0] act, exp;
        bit in_g, e_strt, e_done, rise;
        int win;
        in_g   = m_active && cyc >= m_tstrt && (m_tdone < 0 || cyc <= m_tdone);
        e_strt = m_active && cyc == m_tstrt;
        e_done = m_active && cyc == m_tdone;
        exp = {10'd0, in_g && m_owner == 0, in_g && m_owner == 1,
               e_done && m_owner == 0, e_done && m_owner == 1, e_done && m_abort,
               e_flag, e_strt, e_chnl, e_result};
        act = {10'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.timeout,
               bus.tmo_flag, bus.strt_cnv, bus.chnl, bus.result};
        check("cycle", act, exp);

        if (bus.strt_cnv) begin
            s_cyc.push_back(cyc); s_own.push_back(int'(bus.gnt1)); s_chn.push_back(int'(bus.chnl));
        end
        if (bus.done0 || bus.done1) begin
            d_cyc.push_back(cyc); d_tmo.push_back(int'(bus.timeout)); d_res.push_back(int'(bus.result));
        end

        rise = cm && !prev_cm;
        if (m_active && m_tdone == cyc) begin
            m_active = 0;
            m_fav = 1 - m_owner;
            if (m_owner == 0) p0 = 0; else p1 = 0;
        end else if (m_active && m_tdone < 0 && cyc > m_tstrt) begin
            if (rise) begin
                m_tdone = cyc + 1; m_abort = 0; e_result = rs;
            end else if (cyc == m_tstrt + TMO - 1) begin
                m_tdone = cyc + 1; m_abort = 1;
            end
        end else if (!m_active && cyc >= SDLY && (r0 || r1)) begin
            win = (r0 && r1) ? m_fav : (r1 ? 1 : 0);
            m_active = 1; m_owner = win; m_tstrt = cyc + 1; m_tdone = -1; m_abort = 0;
            e_chnl = (win == 1) ? ch1 : ch0;
            conv_len  = (fix_len > 0) ? fix_len : int'($urandom_range(2, 9));
            conv_hang = fix_hang || ($urandom_range(0, 99) < hang_pct);
        end
        if (m_active && m_abort && m_tdone == cyc + 1) e_flag = 1;
        else if (clr) e_flag = 0;
        prev_cm = cm;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        cmp_upd();
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        drive();
        rst_n = 1;
        @(negedge clk);
        cmp_upd();
    endtask

    task automatic drain();
        req_mode = 0; raise_pct = 0; drop_pct = 0; p0 = 0; p1 = 0;
        for (int i = 0; i < 40 && m_active; i++) step();
        check("drain idle", 32'(m_active), 32'd0);
        step(); step();
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.chnl0 = 0; bus.chnl1 = 0;
        bus.clr_tmo = 0; bus.cnv_cmplt = 1; bus.rslt = 0;
        req_mode = 0; raise_pct = 0; drop_pct = 0; hang_pct = 0; clr_pct = 0;
        fix_hang = 0; stale = 0; clr_at_abort = 0; clr_once = 0;
        model_reset();

        // Request held from reset: startup hold-off, then one conversion.
        p0 = 1; p1 = 0; fix_len = 4; fix_rslt_en = 1; fix_rslt = 12'hA5C;
        fix_ch_en = 1; fix_ch0 = 3'd3; fix_ch1 = 3'd6;
        clear_logs();
        do_reset();
        repeat (18) step();
        check("t1 n_strt", 32'(s_cyc.size()), 32'd1);
        check("t1 strt_cyc", 32'(qget(s_cyc, 0)), 32'd9);
        check("t1 chnl", 32'(qget(s_chn, 0)), 32'd3);
        check("t1 owner", 32'(qget(s_own, 0)), 32'd0);
        check("t1 done_cyc", 32'(qget(d_cyc, 0)), 32'd14);
        check("t1 result", 32'(qget(d_res, 0)), 32'h0A5C);

        // Both requesters held: grants alternate, starting with requester 1.
        req_mode = 1; fix_len = 3; fix_ch0 = 3'd1; fix_ch1 = 3'd5;
        clear_logs();
        repeat (26) step();
        check("t2 owner0", 32'(qget(s_own, 0)), 32'd1);
        check("t2 owner1", 32'(qget(s_own, 1)), 32'd0);
        check("t2 owner2", 32'(qget(s_own, 2)), 32'd1);
        check("t2 owner3", 32'(qget(s_own, 3)), 32'd0);
        check("t2 chnl0", 32'(qget(s_chn, 0)), 32'd5);
        check("t2 chnl1", 32'(qget(s_chn, 1)), 32'd1);
        check("t2 spacing", 32'(qget(s_cyc, 1) - qget(s_cyc, 0)), 32'd6);
        drain();

        // Only requester 1: three back-to-back grants.
        req_mode = 2; fix_len = 5; fix_ch_en = 0; fix_rslt = 12'h3C7;
        clear_logs();
        repeat (20) step();
        drain();
        check("t3 n_strt", 32'(s_cyc.size()), 32'd3);
        check("t3 own", 32'(qget(s_own, 0) + qget(s_own, 1) + qget(s_own, 2)), 32'd3);
        check("t3 gap1", 32'(qget(s_cyc, 1) - qget(s_cyc, 0)), 32'd8);
        check("t3 gap2", 32'(qget(s_cyc, 2) - qget(s_cyc, 1)), 32'd8);
        check("t3 result", 32'(qget(d_res, 2)), 32'h03C7);

        // Hung conversion, clear coinciding with the abort.
        p0 = 1; fix_hang = 1; clr_at_abort = 1;
        clear_logs();
        repeat (22) step();
        drain();
        check("t4 tmo_lat", 32'(qget(d_cyc, 0) - qget(s_cyc, 0)), 32'd16);
        check("t4 timeout", 32'(qget(d_tmo, 0)), 32'd1);
        check("t4 result held", 32'(qget(d_res, 0)), 32'h03C7);
        check("t4 flag set", 32'(bus.tmo_flag), 32'd1);
        fix_hang = 0; clr_at_abort = 0; clr_once = 1;
        step(); step();
        check("t4 flag clr", 32'(bus.tmo_flag), 32'd0);
        p0 = 1; fix_len = 3; fix_rslt = 12'h2B1;
        clear_logs();
        repeat (10) step();
        drain();
        check("t4 next tmo", 32'(qget(d_tmo, 0)), 32'd0);
        check("t4 next res", 32'(qget(d_res, 0)), 32'h02B1);

        // Stale completion edge in the START cycle.
        stale = 1; p1 = 1; fix_len = 12; fix_rslt = 12'h123;
        clear_logs();
        repeat (18) step();
        drain();
        stale = 0;
        check("t5 n_done", 32'(d_cyc.size()), 32'd1);
        check("t5 lat", 32'(qget(d_cyc, 0) - qget(s_cyc, 0)), 32'd13);
        check("t5 result", 32'(qget(d_res, 0)), 32'h0123);

        // Completion on the last allowed cycle vs one cycle too late.
        p0 = 1; fix_len = 15; fix_rslt = 12'h5A5;
        clear_logs();
        repeat (20) step();
        drain();
        check("edge15 lat", 32'(qget(d_cyc, 0) - qget(s_cyc, 0)), 32'd16);
        check("edge15 tmo", 32'(qget(d_tmo, 0)), 32'd0);
        check("edge15 res", 32'(qget(d_res, 0)), 32'h05A5);
        p0 = 1; fix_len = 16; fix_rslt = 12'hFFF;
        clear_logs();
        repeat (20) step();
        drain();
        check("edge16 tmo", 32'(qget(d_tmo, 0)), 32'd1);
        check("edge16 res", 32'(qget(d_res, 0)), 32'h05A5);

        // Asynchronous reset in the middle of a conversion.
        p0 = 1; fix_len = 10;
        clear_logs();
        repeat (5) step();
        check("t6 pre gnt0", 32'(bus.gnt0), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("t6 async clr", {20'd0, bus.gnt0, bus.gnt1, bus.strt_cnv, bus.done0, bus.done1,
                               bus.timeout, bus.tmo_flag, bus.result[4:0]} | 32'(bus.result)
                               | 32'(bus.chnl), 32'd0);
        req_mode = 1; fix_len = 3;
        clear_logs();
        do_reset();
        repeat (12) step();
        check("t6 strt_cyc", 32'(qget(s_cyc, 0)), 32'd9);
        check("t6 owner", 32'(qget(s_own, 0)), 32'd0);

        // Randomized traffic.
        req_mode = 0; p0 = 0; p1 = 0; raise_pct = 30; drop_pct = 5;
        hang_pct = 10; clr_pct = 5; fix_len = 0; fix_rslt_en = 0;
        repeat (800) step();
        clr_pct = 0; hang_pct = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
